pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch stage upstream of the RAM datapath. Holds the 32-bit program counter and fetches one instruction word per step from instruction memory over a request/acknowledge handshake.
- Presents the instruction register to the control unit. That unit decodes it into the datapath control word.
- On each `advance`, it updates PC from the datapath's `PC_in` output according to the control unit's `PS` code.

Parameters:
- `RESET_VECTOR`, `32'h0000_0000`: PC value loaded on reset.
- `PC_STEP`, `4`: byte increment for sequential fetch.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `PS`  in  2  PC update select, sampled on advance: 00 hold, 01 PC+PC_STEP, 10 absolute PC_in, 11 relative PC+(PC_in<<2).
- `PC_in`  in  32  target/offset from the datapath `PC_in` mux (K or register A).
- `advance`  in  1  control unit has consumed IR; apply PS and fetch the next word.
- `imem_data`  in  32  instruction word from instruction memory.
- `imem_ack`  in  1  instruction memory: `imem_data` valid this cycle.
- `imem_addr`  out  32  fetch address; equals PC.
- `imem_rd`  out  1  fetch request.
- `IR`  out  32  instruction register.
- `ir_valid`  out  1  IR holds the word fetched from current PC.
- `PC`  out  32  current program counter.
- `PC4`  out  32  PC+PC_STEP, combinational; used for branch-and-link.
- `misalign`  out  1  sticky: a computed target had bits[1:0] != 0.
- `instr_count`  out  32  number of accepted advances since reset.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - `PC`=`RESET_VECTOR`, `IR`=0, `ir_valid`=0, `misalign`=0, `instr_count`=0, state=REQ.
  - `imem_rd` is forced 0 immediately while `rst`=0.
  - Reset mid-fetch abandons the request. Any `imem_ack` during reset is ignored.
- FSM has two states: REQ and HOLD.
- REQ:
  - `imem_rd`=1, `imem_addr`=`PC`, `ir_valid`=0.
  - On an edge with `imem_ack`=1: `IR`<=`imem_data`, `ir_valid`<=1, go to HOLD.
  - Otherwise stay in REQ with `imem_rd` held high and address stable.
- HOLD:
  - `imem_rd`=0; `IR` and `PC` are stable.
  - On an edge with `advance`=1:
    - `PC`<=next_pc.
    - `ir_valid`<=0.
    - `instr_count`<=`instr_count`+1 (wraps at 2^32).
    - Go to REQ.
  - `advance`=0: remain in HOLD indefinitely.
- Ignored inputs:
  - `advance` in REQ is ignored (no PC change, no count).
  - `imem_ack` in HOLD is ignored.
- next_pc (all arithmetic is 32-bit modulo, no overflow flag):
  - 00: `PC` (same word is re-fetched).
  - 01: `PC`+`PC_STEP`.
  - 10: `PC_in`.
  - 11: `PC` + {`PC_in`[29:0],2'b00}; `PC_in` is a signed word offset, wrap-around allowed.
- Alignment:
  - If next_pc[1:0] != 0: `PC`<=next_pc & ~3 and `misalign`<=1.
  - `misalign` stays set until reset.
- Latency:
  - With memory acking in the same cycle as the request, one fetch takes 1 cycle in REQ; `ir_valid` rises at the following edge.
  - Minimum instruction period is 2 cycles: REQ, then HOLD with `advance`=1.
- First valid IR after reset release: at edge 1 if `imem_ack` is already high.
- `PC4` tracks `PC` combinationally, including the reset value.

Test Plan:
- Reset then sequential fetch: release `rst`, mem acks in same cycle, `PS`=01, `advance` held 1 -> `imem_addr` sequence 0x0,0x4,0x8,0xC; `IR` matches memory words; `instr_count`=3 after the third advance.
- Wait states: `imem_ack` delayed 3 cycles -> `imem_rd` high and `imem_addr` stable 4 cycles; `ir_valid` stays 0 until the ack edge; `advance` pulses during REQ do not change `PC`.
- Absolute branch: `PC`=0x10 in HOLD, `PS`=10, `PC_in`=0x200, advance -> next `imem_addr`=0x200; `PC4`=0x204.
- Relative branch: `PC`=0x40, `PS`=11, `PC_in`=0xFFFF_FFFE (-2) -> `PC`=0x38; `PC`=0xFFFF_FFFC, `PC_in`=1 -> `PC`=0x0 (wrap).
- Misalign: `PS`=10, `PC_in`=0x103 -> `PC`=0x100, `misalign`=1 and stays 1 through later aligned branches until reset.
- Async reset mid-fetch: assert `rst`=0 between edges while in REQ -> `imem_rd` drops without waiting for a clock edge; `PC`=`RESET_VECTOR`, `ir_valid`=0, `instr_count`=0; fetch restarts at the vector on release.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction fetch stage with req/ack memory handshake
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PS,
  input  logic [31:0] PC_in,
  input  logic        advance,
  input  logic [31:0] imem_data,
  input  logic        imem_ack,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        misalign,
  output logic [31:0] instr_count
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  // PS encodings
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_SEQ  = 2'b01;
  localparam logic [1:0] PS_ABS  = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        fetch_done;
  logic        take_adv;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc;
  logic        next_misaligned;

  // The fetch address is always the current PC; PC4 feeds branch-and-link.
  assign imem_addr = PC;
  assign PC4       = PC + STEP;

  // State register; reset abandons any outstanding fetch and restarts at REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode. imem_rd is gated by rst so the request
  // drops the moment reset asserts, without waiting for a clock edge.
  always_comb begin
    state_nxt  = state;
    imem_rd    = 1'b0;
    fetch_done = 1'b0;
    take_adv   = 1'b0;
    unique case (state)
      ST_REQ: begin
        imem_rd = rst;
        if (imem_ack) begin
          fetch_done = 1'b1;
          state_nxt  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (advance) begin
          take_adv  = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      default: begin
        state_nxt = ST_REQ;
      end
    endcase
  end

  // Target selection; all arithmetic wraps modulo 2^32.
  always_comb begin
    next_pc_raw = PC;
    unique case (PS)
      PS_HOLD: next_pc_raw = PC;
      PS_SEQ:  next_pc_raw = PC + STEP;
      PS_ABS:  next_pc_raw = PC_in;
      PS_REL:  next_pc_raw = PC + {PC_in[29:0], 2'b00};
      default: next_pc_raw = PC;
    endcase
  end

  // Targets are forced onto a word boundary; the low bits only feed the flag.
  assign next_misaligned = |next_pc_raw[1:0];
  assign next_pc         = {next_pc_raw[31:2], 2'b00};

  // PC, retired-instruction counter and sticky misalignment flag move only on
  // an accepted advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC          <= RESET_VECTOR;
      instr_count <= 32'd0;
      misalign    <= 1'b0;
    end else if (take_adv) begin
      PC          <= next_pc;
      instr_count <= instr_count + 32'd1;
      if (next_misaligned) begin
        misalign <= 1'b1;
      end
    end
  end

  // Instruction register captures the acked word; valid clears on advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IR       <= 32'd0;
      ir_valid <= 1'b0;
    end else if (fetch_done) begin
      IR       <= imem_data;
      ir_valid <= 1'b1;
    end else if (take_adv) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  PS;
  logic [31:0] PC_in;
  logic        advance;
  logic [31:0] imem_data;
  logic        imem_ack;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] IR;
  logic        ir_valid;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        misalign;
  logic [31:0] instr_count;

  int n_cmp = 0;
  int n_mis = 0;

  int ack_delay = 0;
  int wait_cnt  = 0;
  logic spurious_ack = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_t;
  fetch_t exp_q[$];

  logic [31:0] model_pc;
  logic [31:0] model_cnt;
  logic        model_mis;

  pc_fetch_unit #(.RESET_VECTOR(RV), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .PS(PS), .PC_in(PC_in), .advance(advance),
    .imem_data(imem_data), .imem_ack(imem_ack), .imem_addr(imem_addr),
    .imem_rd(imem_rd), .IR(IR), .ir_valid(ir_valid), .PC(PC), .PC4(PC4),
    .misalign(misalign), .instr_count(instr_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data follows address, ack after ack_delay extra request cycles.
  assign imem_data = mem_word(imem_addr);
  assign imem_ack  = (imem_rd && (wait_cnt > ack_delay)) || spurious_ack;

  always @(negedge clk) begin
    if (imem_rd) wait_cnt = wait_cnt + 1;
    else         wait_cnt = 0;
  end

  task automatic wait_hold(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (ir_valid === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // One accepted advance from HOLD, then wait for and score the refetch.
  task automatic step(input logic [1:0] ps, input logic [31:0] pc_in, input string tag);
    logic [31:0] nxt;
    fetch_t e;
    bit to;
    PS = ps; PC_in = pc_in; advance = 1'b1;
    case (ps)
      2'b00:   nxt = model_pc;
      2'b01:   nxt = model_pc + 32'd4;
      2'b10:   nxt = pc_in;
      default: nxt = model_pc + {pc_in[29:0], 2'b00};
    endcase
    if (nxt[1:0] != 2'b00) model_mis = 1'b1;
    model_pc  = {nxt[31:2], 2'b00};
    model_cnt = model_cnt + 32'd1;
    exp_q.push_back('{addr: model_pc, data: mem_word(model_pc)});
    @(posedge clk); #1;
    advance = 1'b0;
    n_cmp++;
    if (imem_addr !== model_pc) begin
      n_mis++; $display("FAIL %s_addr: got %h expected %h", tag, imem_addr, model_pc);
    end
    n_cmp++;
    if (PC4 !== model_pc + 32'd4) begin
      n_mis++; $display("FAIL %s_pc4: got %h expected %h", tag, PC4, model_pc + 32'd4);
    end
    n_cmp++;
    if (instr_count !== model_cnt) begin
      n_mis++; $display("FAIL %s_count: got %0d expected %0d", tag, instr_count, model_cnt);
    end
    n_cmp++;
    if (misalign !== model_mis) begin
      n_mis++; $display("FAIL %s_misalign: got %b expected %b", tag, misalign, model_mis);
    end
    wait_hold(to);
    n_cmp++;
    if (to) begin
      n_mis++; $display("FAIL %s_timeout: got ir_valid %b expected 1", tag, ir_valid);
    end else if (exp_q.size() == 0) begin
      n_mis++; $display("FAIL %s_queue: got empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      if (IR !== e.data || PC !== e.addr || imem_rd !== 1'b0) begin
        n_mis++;
        $display("FAIL %s_fetch: got IR %h PC %h rd %b expected IR %h PC %h rd 0",
                 tag, IR, PC, imem_rd, e.data, e.addr);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (PC !== RV || PC4 !== RV + 32'd4 || IR !== 32'd0) begin
      n_mis++; $display("FAIL reset_regs: got PC %h PC4 %h IR %h expected %h %h 0", PC, PC4, IR, RV, RV + 32'd4);
    end
    n_cmp++;
    if (ir_valid !== 1'b0 || misalign !== 1'b0 || instr_count !== 32'd0 || imem_rd !== 1'b0) begin
      n_mis++; $display("FAIL reset_flags: got v %b m %b cnt %0d rd %b expected 0 0 0 0", ir_valid, misalign, instr_count, imem_rd);
    end
    spurious_ack = 1'b1;
    @(posedge clk); #1;
    spurious_ack = 1'b0;
    n_cmp++;
    if (ir_valid !== 1'b0 || IR !== 32'd0) begin
      n_mis++; $display("FAIL reset_ack_ignored: got v %b IR %h expected 0 0", ir_valid, IR);
    end
  endtask

  task automatic test_sequential();
    fetch_t e;
    model_pc = RV; model_cnt = 32'd0; model_mis = 1'b0;
    rst = 1'b1;
    exp_q.push_back('{addr: RV, data: mem_word(RV)});
    #1;
    n_cmp++;
    if (imem_rd !== 1'b1 || imem_addr !== RV) begin
      n_mis++; $display("FAIL seq_first_req: got rd %b addr %h expected 1 %h", imem_rd, imem_addr, RV);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ir_valid !== 1'b1) begin
      n_mis++; $display("FAIL seq_first_valid: got %b expected 1", ir_valid);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (IR !== e.data || PC !== e.addr) begin
        n_mis++; $display("FAIL seq_first_ir: got IR %h PC %h expected %h %h", IR, PC, e.data, e.addr);
      end
    end
    for (int i = 0; i < 3; i++) step(2'b01, 32'd0, "seq");
    n_cmp++;
    if (instr_count !== 32'd3 || PC !== 32'h0000_000C) begin
      n_mis++; $display("FAIL seq_final: got cnt %0d PC %h expected 3 0000000c", instr_count, PC);
    end
  endtask

  task automatic test_wait_states();
    fetch_t e;
    ack_delay = 3;
    PS = 2'b01; advance = 1'b1;
    model_pc  = model_pc + 32'd4;
    model_cnt = model_cnt + 32'd1;
    exp_q.push_back('{addr: model_pc, data: mem_word(model_pc)});
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (imem_rd !== 1'b1 || imem_addr !== model_pc || ir_valid !== 1'b0 || PC !== model_pc) begin
        n_mis++;
        $display("FAIL wait_req%0d: got rd %b addr %h v %b PC %h expected 1 %h 0 %h",
                 i, imem_rd, imem_addr, ir_valid, PC, model_pc, model_pc);
      end
      advance = (i % 2 == 0);
      PS = 2'b10; PC_in = 32'h0000_0500;
      @(posedge clk); #1;
    end
    advance = 1'b0;
    n_cmp++;
    if (ir_valid !== 1'b1 || PC !== model_pc || instr_count !== model_cnt) begin
      n_mis++; $display("FAIL wait_done: got v %b PC %h cnt %0d expected 1 %h %0d", ir_valid, PC, instr_count, model_pc, model_cnt);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (IR !== e.data) begin
      n_mis++; $display("FAIL wait_ir: got %h expected %h", IR, e.data);
    end
    ack_delay = 0;
    spurious_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    spurious_ack = 1'b0;
    n_cmp++;
    if (ir_valid !== 1'b1 || IR !== e.data || imem_rd !== 1'b0) begin
      n_mis++; $display("FAIL hold_ack_ignored: got v %b IR %h rd %b expected 1 %h 0", ir_valid, IR, imem_rd, e.data);
    end
  endtask

  task automatic test_branches();
    step(2'b10, 32'h0000_0200, "abs");
    n_cmp++;
    if (PC4 !== 32'h0000_0204) begin
      n_mis++; $display("FAIL abs_pc4: got %h expected 00000204", PC4);
    end
    step(2'b10, 32'h0000_0040, "rel_setup");
    step(2'b11, 32'hFFFF_FFFE, "rel_back");
    n_cmp++;
    if (PC !== 32'h0000_0038) begin
      n_mis++; $display("FAIL rel_back_pc: got %h expected 00000038", PC);
    end
    step(2'b10, 32'hFFFF_FFFC, "wrap_setup");
    step(2'b11, 32'h0000_0001, "rel_wrap");
    n_cmp++;
    if (PC !== 32'h0000_0000) begin
      n_mis++; $display("FAIL rel_wrap_pc: got %h expected 00000000", PC);
    end
  endtask

  task automatic test_misalign();
    n_cmp++;
    if (misalign !== 1'b0) begin
      n_mis++; $display("FAIL misalign_pre: got %b expected 0", misalign);
    end
    step(2'b10, 32'h0000_0103, "mis");
    n_cmp++;
    if (PC !== 32'h0000_0100 || misalign !== 1'b1) begin
      n_mis++; $display("FAIL mis_pc: got PC %h m %b expected 00000100 1", PC, misalign);
    end
    step(2'b10, 32'h0000_0300, "mis_sticky");
    step(2'b00, 32'h0000_0000, "mis_refetch");
    n_cmp++;
    if (misalign !== 1'b1 || PC !== 32'h0000_0300) begin
      n_mis++; $display("FAIL mis_hold: got m %b PC %h expected 1 00000300", misalign, PC);
    end
  endtask

  task automatic test_async_reset();
    fetch_t e;
    ack_delay = 5;
    PS = 2'b01; advance = 1'b1;
    @(posedge clk); #1;
    advance = 1'b0;
    #2;
    rst = 1'b0;
    spurious_ack = 1'b1;
    #1;
    n_cmp++;
    if (imem_rd !== 1'b0) begin
      n_mis++; $display("FAIL areset_rd: got %b expected 0", imem_rd);
    end
    n_cmp++;
    if (PC !== RV || ir_valid !== 1'b0 || instr_count !== 32'd0 || misalign !== 1'b0) begin
      n_mis++; $display("FAIL areset_state: got PC %h v %b cnt %0d m %b expected %h 0 0 0", PC, ir_valid, instr_count, misalign, RV);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ir_valid !== 1'b0 || IR !== 32'd0) begin
      n_mis++; $display("FAIL areset_hold: got v %b IR %h expected 0 0", ir_valid, IR);
    end
    spurious_ack = 1'b0;
    ack_delay = 0;
    exp_q.delete();
    model_pc = RV; model_cnt = 32'd0; model_mis = 1'b0;
    rst = 1'b1;
    exp_q.push_back('{addr: RV, data: mem_word(RV)});
    #1;
    n_cmp++;
    if (imem_rd !== 1'b1 || imem_addr !== RV) begin
      n_mis++; $display("FAIL areset_restart: got rd %b addr %h expected 1 %h", imem_rd, imem_addr, RV);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ir_valid !== 1'b1) begin
      n_mis++; $display("FAIL areset_refetch: got v %b expected 1", ir_valid);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (IR !== e.data || PC !== e.addr) begin
        n_mis++; $display("FAIL areset_ir: got IR %h PC %h expected %h %h", IR, PC, e.data, e.addr);
      end
    end
    step(2'b01, 32'd0, "post_reset");
  endtask

  initial begin
    rst = 1'b0; PS = 2'b00; PC_in = 32'd0; advance = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_sequential();
    test_wait_states();
    test_branches();
    test_misalign();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
